// File: rtl/coin_payout_if.sv
// coin_payout_if
//   Bundles every non-clock signal of the coin payout controller.
//
//   Request handshake: a payout request is accepted on a rising clock edge
//   where amt_valid=1 and amt_ready=1. amt_ready is high only while the
//   controller is idle, and amt_valid is ignored on any edge where
//   amt_ready=0. No request is ever held pending.
//
//   Signals
//     amt_valid, amt[2:0]          request strobe and amount in coin units
//     amt_ready                    controller idle, request can be taken
//     eject_c1, eject_c2           one-cycle eject command to the hopper
//     eject_ack                    hopper reports one coin ejected
//     refill_c1, refill_c2         add one coin to the matching stock
//     stock_c1, stock_c2 [3:0]     coin inventory
//     busy, done, short            status and completion pulses
//     short_amt[2:0]               unpaid residual while short=1
//     state_dbg[2:0]               controller state, for observation only
//
//   Modports: master = requester/hopper side, slave = controller.
interface coin_payout_if;
    logic       amt_valid;
    logic [2:0] amt;
    logic       amt_ready;
    logic       eject_c1;
    logic       eject_c2;
    logic       eject_ack;
    logic       refill_c1;
    logic       refill_c2;
    logic [3:0] stock_c1;
    logic [3:0] stock_c2;
    logic       busy;
    logic       done;
    logic       short;
    logic [2:0] short_amt;
    logic [2:0] state_dbg;

    modport master (
        output amt_valid, amt, eject_ack, refill_c1, refill_c2,
        input  amt_ready, eject_c1, eject_c2, stock_c1, stock_c2,
               busy, done, short, short_amt, state_dbg
    );

    modport slave (
        input  amt_valid, amt, eject_ack, refill_c1, refill_c2,
        output amt_ready, eject_c1, eject_c2, stock_c1, stock_c2,
               busy, done, short, short_amt, state_dbg
    );
endinterface

// File: rtl/coin_payout.sv
// coin_payout
//   Pays out a requested amount (0..7 units) from two coin stocks (value 1
//   and value 2), largest coin first, one coin at a time with a hopper
//   acknowledge per coin. A missing acknowledge for TIMEOUT cycles is
//   treated as a hopper jam and the payout ends short.
//
//   Ports
//     clk   clock, all state updates on the rising edge
//     rst   synchronous, active-high reset
//     bus   coin_payout_if.slave (request, hopper, refill, stock, status)
//
//   Parameter
//     TIMEOUT  cycles spent in WAIT_ACK before a jam is declared
//
//   Build option
//     PAYOUT_PRECHECK_EN  when defined, a request that the current stock
//                         cannot cover ends short before any coin is
//                         ejected, reporting the whole amount as unpaid.
//
//   All outputs are registered: each is loaded from the next-state values.
module coin_payout #(
    parameter int TIMEOUT = 8
) (
    input  logic         clk,
    input  logic         rst,
    coin_payout_if.slave bus
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_WAIT_ACK,
        S_DONE,
        S_SHORT
    } state_t;

    state_t        state, state_n;
    logic [2:0]    rem, rem_n;
    logic          coin2, coin2_n;   // coin in flight is the value-2 coin
    logic [CW-1:0] cnt, cnt_n;
    logic          dec1, dec2;
    logic [3:0]    stock1, stock2;
    logic          pre_short;

    logic          eject1_q, eject2_q, done_q, short_q, busy_q, ready_q;
    logic [2:0]    short_amt_q;

`ifdef PAYOUT_PRECHECK_EN
    // Coins of value 2 usable for this amount, then value-1 coins needed.
    logic [1:0] use2;
    logic [2:0] need1;
    assign use2      = (stock2 < {2'b00, bus.amt[2:1]}) ? stock2[1:0] : bus.amt[2:1];
    assign need1     = bus.amt - {use2, 1'b0};
    assign pre_short = ({1'b0, need1} > stock1);
`else
    assign pre_short = 1'b0;
`endif

    // Refill and acknowledge on the same stock in one cycle cancel out.
    function automatic logic [3:0] stock_next(logic [3:0] s, logic inc, logic dec);
        logic [3:0] r;
        r = s;
        if (inc && !dec && s != 4'd15) r = s + 4'd1;
        else if (dec && !inc)          r = s - 4'd1;
        return r;
    endfunction

    always_comb begin
        state_n = state;
        rem_n   = rem;
        coin2_n = coin2;
        cnt_n   = cnt;
        dec1    = 1'b0;
        dec2    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.amt_valid) begin
                    if (bus.amt == 3'd0) begin
                        state_n = S_DONE;
                    end else begin
                        rem_n   = bus.amt;
                        state_n = pre_short ? S_SHORT : S_SELECT;
                    end
                end
            end
            S_SELECT: begin
                if (rem == 3'd0) begin
                    state_n = S_DONE;
                end else if (rem >= 3'd2 && stock2 != 4'd0) begin
                    coin2_n = 1'b1;
                    state_n = S_EJECT;
                end else if (stock1 != 4'd0) begin
                    coin2_n = 1'b0;
                    state_n = S_EJECT;
                end else begin
                    state_n = S_SHORT;
                end
            end
            S_EJECT: begin
                cnt_n   = '0;
                state_n = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                // An acknowledge in the last allowed cycle still counts.
                if (bus.eject_ack) begin
                    rem_n   = rem - (coin2 ? 3'd2 : 3'd1);
                    dec1    = !coin2;
                    dec2    = coin2;
                    state_n = S_SELECT;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    state_n = S_SHORT;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_DONE:  state_n = S_IDLE;
            S_SHORT: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            rem         <= 3'd0;
            coin2       <= 1'b0;
            cnt         <= '0;
            stock1      <= 4'd0;
            stock2      <= 4'd0;
            eject1_q    <= 1'b0;
            eject2_q    <= 1'b0;
            done_q      <= 1'b0;
            short_q     <= 1'b0;
            short_amt_q <= 3'd0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state       <= state_n;
            rem         <= rem_n;
            coin2       <= coin2_n;
            cnt         <= cnt_n;
            stock1      <= stock_next(stock1, bus.refill_c1, dec1);
            stock2      <= stock_next(stock2, bus.refill_c2, dec2);
            eject1_q    <= (state_n == S_EJECT) && !coin2_n;
            eject2_q    <= (state_n == S_EJECT) && coin2_n;
            done_q      <= (state_n == S_DONE);
            short_q     <= (state_n == S_SHORT);
            short_amt_q <= (state_n == S_SHORT) ? rem_n : 3'd0;
            busy_q      <= (state_n != S_IDLE);
            ready_q     <= (state_n == S_IDLE);
        end
    end

    assign bus.eject_c1  = eject1_q;
    assign bus.eject_c2  = eject2_q;
    assign bus.done      = done_q;
    assign bus.short     = short_q;
    assign bus.short_amt = short_amt_q;
    assign bus.busy      = busy_q;
    assign bus.amt_ready = ready_q;
    assign bus.stock_c1  = stock1;
    assign bus.stock_c2  = stock2;
    assign bus.state_dbg = state;
endmodule

// File: doc/coin_payout.md
COIN_PAYOUT -- requirements
Module: coin_payout

Interface
REQ-001 Parameter: TIMEOUT, default 8, max cycles spent in WAIT_ACK before a hopper jam is declared.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 amt_valid  input  1  payout request strobe, sampled only while amt_ready=1.
REQ-005 amt  input  3  amount to pay out, in coin units 0..7 (vending machine cng/rtn value).
REQ-006 amt_ready  output  1  high only in IDLE.
REQ-007 eject_c1 / eject_c2  output  1 each  one-cycle command to the hopper to eject one value-1 / value-2 coin.
REQ-008 eject_ack  input  1  hopper confirms one coin left the hopper.
REQ-009 refill_c1 / refill_c2  input  1 each  each high cycle adds one coin to that stock.
REQ-010 stock_c1 / stock_c2  output  4 each  current coin inventory.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse: full amount paid.
REQ-013 short  output  1  one-cycle pulse: payout ended with an unpaid residual.
REQ-014 short_amt  output  3  unpaid residual; valid while short=1, 0 otherwise.

Function
REQ-015 FSM states: IDLE, SELECT, EJECT, WAIT_ACK, DONE, SHORT; all outputs registered.
REQ-016 IDLE: amt_valid=1 and amt!=0 -> latch rem=amt, go to SELECT. amt_valid=1 and amt=0 -> DONE. amt_valid is ignored in all other states.
REQ-017 SELECT priority: rem=0 -> DONE; rem>=2 and stock_c2>0 -> EJECT with coin=2; rem>=1 and stock_c1>0 -> EJECT with coin=1; otherwise -> SHORT.
REQ-018 EJECT: assert exactly one of eject_c1/eject_c2 for exactly one cycle, clear the timeout counter, go to WAIT_ACK.
REQ-019 WAIT_ACK, eject_ack=1: rem -= coin, selected stock -= 1, go to SELECT.
REQ-020 WAIT_ACK with no ack for TIMEOUT consecutive cycles -> SHORT; rem and stock are unchanged.
REQ-021 eject_ack outside WAIT_ACK is ignored.
REQ-022 DONE: done=1 for one cycle, then IDLE. SHORT: short=1 and short_amt=rem for one cycle, then IDLE.
REQ-023 Latency with immediate ack: request in cycle T; eject asserted in T+2; ack in T+3; next SELECT in T+4. amt=2 with stock_c2>0 gives done in T+5.
REQ-024 Stock arithmetic: a refill increment saturates at 15. A refill and an ack decrement of the same stock in one cycle leave the stock unchanged. A stock never underflows; SELECT guarantees it is nonzero before ejecting.
REQ-025 Refill inputs are accepted in every state, including during a payout.

Reset
REQ-026 While rst=1 at posedge clk: state=IDLE, rem=0, stock_c1=stock_c2=0, timeout counter=0, eject_c1=eject_c2=done=short=busy=0, short_amt=0. amt_ready=1 from the first cycle after reset.
REQ-027 Reset during any payout aborts it with no done/short pulse; coins already acknowledged are not restored to stock.

Configuration
REQ-028 Macro PAYOUT_PRECHECK_EN defined: on leaving IDLE with amt!=0, compute need1 = amt - 2*min(stock_c2, amt>>1).
  - If need1 > stock_c1: go directly to SHORT with short_amt=amt; nothing is ejected.
  - Otherwise proceed to SELECT.
REQ-029 PAYOUT_PRECHECK_EN undefined: no precheck; a partial payout ends in SHORT with the residual per REQ-017.

Verification
REQ-030 Refill 2x c2 and 3x c1, then amt=5, ack 1 cycle after each eject -> ejects c2, c2, c1; done; stocks 0/2 (c2/c1).
REQ-031 Stocks c2=0, c1=1, amt=3, precheck undefined -> one c1 ejected; short=1, short_amt=2; stock_c1=0.
REQ-032 Same stimulus as REQ-031, PAYOUT_PRECHECK_EN defined -> no eject; short=1, short_amt=3; stock_c1 stays 1.
REQ-033 c2 stock 1, amt=2, eject_ack withheld -> short after TIMEOUT=8 cycles in WAIT_ACK; short_amt=2; stock_c2 stays 1.
REQ-034 16 refill_c1 pulses -> stock_c1=15. Then refill_c1 coincides with a c1 ack -> stock_c1 unchanged. Then amt=0 -> done 1 cycle after request, no eject.
REQ-035 rst=1 in WAIT_ACK -> next cycle IDLE, all outputs 0 except amt_ready=1, stocks 0; late eject_ack ignored.
